fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch side of the control path. Consumes the 28-bit
//  control word from the microcoded controller and serves its ROM/PC fields:
//  ROMrd, ROMcs, PCHbus, PCLbus, PCHcar, PCLcar and EOI.
//  Fetches opcodes and operands from program ROM over a req/ack handshake.
//  Drives the 8-bit opcode back to the controller.
// PARAMETERS
//  RESET_VECTOR  16'h0000  PC value loaded on reset
//  MAX_WAIT      15        cycles to wait for rom_ack before faulting (1..255)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  ctrl_signals  in   28  controller word; bits used: 0 ROMrd, 1 ROMcs, 2 PCHbus, 3 PCLbus,
//                         4 PCHcar, 5 PCLcar, 27 EOI; other bits ignored
//  bus_in        in   8   shared data bus, value seen by this block
//  bus_out       out  8   value this block drives onto the shared bus
//  bus_oe        out  1   bus_out valid / drive enable
//  rom_addr      out  16  ROM address, held stable while rom_req=1
//  rom_req       out  1   ROM read request, level
//  rom_ack       in   1   ROM data valid this cycle; rom_data sampled on the same edge
//  rom_data      in   8   ROM read data
//  instruction   out  8   instruction register (opcode) to the controller
//  instr_valid   out  1   instruction holds a freshly fetched opcode (EXEC state)
//  pc            out  16  current program counter {PCH,PCL}
//  fault         out  1   sticky: ROM timeout or PCHbus+PCLbus conflict; cleared only by reset
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - pc=RESET_VECTOR; instruction=8'h00; all other outputs 0
//   - state=FETCH; wait counter=0
//  States:
//   - FETCH: rom_req=1, rom_addr=pc; on rom_ack: instruction<=rom_data, pc<=pc+1,
//     instr_valid<=1, ->EXEC
//   - EXEC: decode strobes each cycle (priority below)
//   - OPND: operand read; rom_req=1, rom_addr=pc; on rom_ack: bus_out<=rom_data,
//     bus_oe<=1 for one cycle, pc<=pc+1, ->EXEC
//   - HALT: entered on fault; rom_req=0; outputs frozen; exit only by reset
//  EXEC priority (highest first):
//   1. PCHbus&PCLbus both 1: fault<=1, ->HALT
//   2. PCHcar / PCLcar: PC[15:8] / PC[7:0] <= bus_in (both may load in the same cycle)
//   3. PCHbus / PCLbus: bus_out=PC[15:8] / PC[7:0], bus_oe=1, combinational in the same cycle
//   4. ROMcs&ROMrd (no car bit set): ->OPND. ROMcs alone or ROMrd alone: no action
//  EOI:
//   - Sampled in EXEC after the actions above; ->FETCH next cycle, instr_valid<=0
//   - A car load in the same cycle takes effect first; the fetch uses the new pc
//   - EOI together with ROMcs&ROMrd: the operand read is dropped and EOI wins
//  Latency:
//   - opcode valid 1 cycle after rom_ack; minimum fetch is 1 cycle (ack in the request cycle)
//  Arithmetic:
//   - pc increment is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000, no flag
//  Timeout:
//   - Wait counter runs in FETCH/OPND while rom_ack=0 and clears on ack
//   - Counter reaching MAX_WAIT: fault<=1, ->HALT
//  Strobes outside EXEC are ignored. bus_oe=0 whenever not driving.
//  Reset mid-fetch: rom_req drops asynchronously; the fetch restarts at RESET_VECTOR.
// STRUCTURE
//  - Shared package (cpu_pkg): ctrl_signals bit-index constants (ROMRD=0 .. EOI=27),
//    fetch state encoding (FETCH, EXEC, OPND, HALT)
//  - One sub-module: pc_reg (16-bit PC: split high/low parallel load, increment with wrap,
//    async reset to RESET_VECTOR)
// TESTING
//  1. Reset release, ROM acks after 2 cycles with 8'hA5 -> rom_addr=0000, instruction=A5,
//     pc=0001, instr_valid=1
//  2. EXEC with PCHcar,PCLcar, bus_in=8'h12 then 8'h34 over two cycles, then EOI ->
//     next fetch at rom_addr=1234
//  3. pc=FFFF, fetch acked -> pc=0000; then ROMcs&ROMrd with ack data 8'h5C ->
//     bus_out=5C, bus_oe=1 for one cycle, pc=0001
//  4. PCHbus then PCLbus with pc=BEEF -> bus_out=BE then EF, bus_oe=1 in each cycle;
//     both set at once -> fault=1, HALT
//  5. rom_ack held 0 for MAX_WAIT cycles -> fault=1, rom_req=0; rst_n pulse -> fault=0,
//     refetch at RESET_VECTOR
//  6. EOI with ROMcs&ROMrd in the same cycle -> no operand read, FETCH, rom_addr=pc

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-path definitions for the fetch unit.
// Holds the bit positions of the fetch-related fields in the 28-bit
// controller word and the fetch FSM state encoding.
package cpu_pkg;

   // Bit positions inside ctrl_signals
   localparam int unsigned ROMRD  = 0;
   localparam int unsigned ROMCS  = 1;
   localparam int unsigned PCHBUS = 2;
   localparam int unsigned PCLBUS = 3;
   localparam int unsigned PCHCAR = 4;
   localparam int unsigned PCLCAR = 5;
   localparam int unsigned EOI    = 27;

   // Fetch FSM encoding
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_FETCH = 2'd0;
   localparam fetch_state_t ST_EXEC  = 2'd1;
   localparam fetch_state_t ST_OPND  = 2'd2;
   localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Program ROM read port: level request with address, single-cycle ack with data.
//   rom_addr  fetch -> ROM  address, stable while rom_req=1
//   rom_req   fetch -> ROM  read request (level)
//   rom_ack   ROM -> fetch  data valid this cycle
//   rom_data  ROM -> fetch  read data
interface fetch_unit_if;
   logic [15:0] rom_addr;
   logic        rom_req;
   logic        rom_ack;
   logic [7:0]  rom_data;

   modport master (output rom_addr, output rom_req, input rom_ack, input rom_data);
   modport slave  (input rom_addr, input rom_req, output rom_ack, output rom_data);
endinterface

// File: rtl/pc_reg.sv
// 16-bit program counter with independent high/low byte parallel load and
// modulo-2^16 increment. Async active-low reset to RESET_VECTOR.
//   clk, rst_n         clock / async reset
//   ld_hi_i, ld_lo_i   load PC[15:8] / PC[7:0] from din_i
//   inc_i              increment PC (wraps FFFF -> 0000)
//   din_i              byte load data
//   pc_o               current PC
module pc_reg #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_hi_i,
   input  logic        ld_lo_i,
   input  logic        inc_i,
   input  logic [7:0]  din_i,
   output logic [15:0] pc_o
);

   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (inc_i)   pc_d = pc_q + 16'd1;
      if (ld_hi_i) pc_d[15:8] = din_i;
      if (ld_lo_i) pc_d[7:0]  = din_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_VECTOR;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch side of the control path.
// Fetches opcodes and operands from program ROM, serves the controller's
// ROM/PC strobes (ROMrd, ROMcs, PCHbus, PCLbus, PCHcar, PCLcar, EOI) and
// returns the fetched opcode.
//   clk, rst_n     clock / async active-low reset
//   ctrl_signals   controller word (only fetch-related bits used)
//   bus_in         shared data bus as seen by this block
//   bus_out/bus_oe value and drive enable onto the shared bus
//   rom            ROM read port (master side)
//   instruction    opcode register; instr_valid while a fresh opcode is held
//   pc             program counter
//   fault          sticky ROM timeout / PCHbus+PCLbus conflict
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned MAX_WAIT     = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [27:0]         ctrl_signals,
   input  logic [7:0]          bus_in,
   output logic [7:0]          bus_out,
   output logic                bus_oe,
   fetch_unit_if.master        rom,
   output logic [7:0]          instruction,
   output logic                instr_valid,
   output logic [15:0]         pc,
   output logic                fault
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   fetch_state_t state_q, state_d;
   logic [7:0]   wait_q, wait_d;
   logic [7:0]   instr_q, instr_d;
   logic         ivalid_q, ivalid_d;
   logic         fault_q, fault_d;
   logic [7:0]   opnd_q, opnd_d;
   logic         opnd_oe_q, opnd_oe_d;
   logic         ld_hi, ld_lo, pc_inc;

   logic rom_rd, rom_cs, pch_bus, pcl_bus, pch_car, pcl_car, eoi;
   logic unused_ctrl;

   assign rom_rd  = ctrl_signals[ROMRD];
   assign rom_cs  = ctrl_signals[ROMCS];
   assign pch_bus = ctrl_signals[PCHBUS];
   assign pcl_bus = ctrl_signals[PCLBUS];
   assign pch_car = ctrl_signals[PCHCAR];
   assign pcl_car = ctrl_signals[PCLCAR];
   assign eoi     = ctrl_signals[EOI];
   assign unused_ctrl = ^ctrl_signals[26:6];

   pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_hi_i (ld_hi),
      .ld_lo_i (ld_lo),
      .inc_i   (pc_inc),
      .din_i   (bus_in),
      .pc_o    (pc)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      instr_d   = instr_q;
      ivalid_d  = ivalid_q;
      fault_d   = fault_q;
      opnd_d    = opnd_q;
      opnd_oe_d = 1'b0;
      ld_hi     = 1'b0;
      ld_lo     = 1'b0;
      pc_inc    = 1'b0;
      bus_out   = '0;
      bus_oe    = 1'b0;

      // Operand captured on the previous edge is presented for exactly one cycle
      if (opnd_oe_q) begin
         bus_out = opnd_q;
         bus_oe  = 1'b1;
      end

      case (state_q)
         ST_FETCH, ST_OPND: begin
            if (rom.rom_ack) begin
               wait_d  = '0;
               pc_inc  = 1'b1;
               state_d = ST_EXEC;
               if (state_q == ST_FETCH) begin
                  instr_d  = rom.rom_data;
                  ivalid_d = 1'b1;
               end else begin
                  opnd_d    = rom.rom_data;
                  opnd_oe_d = 1'b1;
               end
            end else if (wait_q == WAIT_LAST) begin
               fault_d = 1'b1;
               state_d = ST_HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_EXEC: begin
            if (pch_bus && pcl_bus) begin
               fault_d = 1'b1;
               state_d = ST_HALT;
            end else begin
               ld_hi = pch_car;
               ld_lo = pcl_car;
               if (pch_bus) begin
                  bus_out = pc[15:8];
                  bus_oe  = 1'b1;
               end else if (pcl_bus) begin
                  bus_out = pc[7:0];
                  bus_oe  = 1'b1;
               end
               // EOI overrides an operand read requested in the same cycle
               if (eoi) begin
                  state_d  = ST_FETCH;
                  ivalid_d = 1'b0;
               end else if (rom_cs && rom_rd && !pch_car && !pcl_car) begin
                  state_d = ST_OPND;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         instr_q   <= '0;
         ivalid_q  <= 1'b0;
         fault_q   <= 1'b0;
         opnd_q    <= '0;
         opnd_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instr_q   <= instr_d;
         ivalid_q  <= ivalid_d;
         fault_q   <= fault_d;
         opnd_q    <= opnd_d;
         opnd_oe_q <= opnd_oe_d;
      end
   end

   // Request is gated by rst_n so it drops immediately on an async reset
   assign rom.rom_req  = rst_n && ((state_q == ST_FETCH) || (state_q == ST_OPND));
   assign rom.rom_addr = pc;
   assign instruction  = instr_q;
   assign instr_valid  = ivalid_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [27:0] ctrl_signals = '0;
   logic [7:0]  bus_in = '0;
   logic [7:0]  bus_out;
   logic        bus_oe;
   logic [7:0]  instruction;
   logic        instr_valid;
   logic [15:0] pc;
   logic        fault;

   fetch_unit_if rom_bus ();

   fetch_unit #(.RESET_VECTOR(16'h0000), .MAX_WAIT(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl_signals (ctrl_signals),
      .bus_in       (bus_in),
      .bus_out      (bus_out),
      .bus_oe       (bus_oe),
      .rom          (rom_bus),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] q_req[$];    // rom_addr at each new request
   logic [23:0] q_fetch[$];  // {instruction, pc} when instr_valid rises
   logic [7:0]  q_bus[$];    // bus_out on each bus_oe cycle
   logic [8:0]  q_fault[$];  // {rom_req, unacked request cycles} when fault rises

   localparam logic [27:0] C_RD  = 28'(1) << ROMRD;
   localparam logic [27:0] C_CS  = 28'(1) << ROMCS;
   localparam logic [27:0] C_HB  = 28'(1) << PCHBUS;
   localparam logic [27:0] C_LB  = 28'(1) << PCLBUS;
   localparam logic [27:0] C_HC  = 28'(1) << PCHCAR;
   localparam logic [27:0] C_LC  = 28'(1) << PCLCAR;
   localparam logic [27:0] C_EOI = 28'(1) << EOI;

   // ---------------- monitor / scoreboard ----------------
   logic prev_req = 1'b0, prev_iv = 1'b0, prev_fault = 1'b0;
   int   nak = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         n_cmp++;
         if ({rom_bus.rom_req, rom_bus.rom_addr, bus_oe, instruction, instr_valid, pc, fault} !== 43'h0) begin
            n_err++;
            $display("FAIL reset_state: req=%b addr=%h oe=%b instr=%h iv=%b pc=%h fault=%b, required all zero",
                     rom_bus.rom_req, rom_bus.rom_addr, bus_oe, instruction, instr_valid, pc, fault);
         end
      end else begin
         if (rom_bus.rom_req && !prev_req) begin
            nak = 0;
            n_cmp++;
            if (q_req.size() == 0) begin
               n_err++;
               $display("FAIL req_addr: unexpected request at %h", rom_bus.rom_addr);
            end else begin
               logic [15:0] e;
               e = q_req.pop_front();
               if (rom_bus.rom_addr !== e) begin
                  n_err++;
                  $display("FAIL req_addr: got %h required %h", rom_bus.rom_addr, e);
               end
            end
         end
         if (rom_bus.rom_req) nak = rom_bus.rom_ack ? 0 : nak + 1;

         if (instr_valid && !prev_iv) begin
            n_cmp++;
            if (q_fetch.size() == 0) begin
               n_err++;
               $display("FAIL fetch: unexpected opcode %h pc=%h", instruction, pc);
            end else begin
               logic [23:0] e;
               e = q_fetch.pop_front();
               if ({instruction, pc} !== e) begin
                  n_err++;
                  $display("FAIL fetch: got instr=%h pc=%h required instr=%h pc=%h",
                           instruction, pc, e[23:16], e[15:0]);
               end
            end
         end

         if (bus_oe) begin
            n_cmp++;
            if (q_bus.size() == 0) begin
               n_err++;
               $display("FAIL bus_out: unexpected drive %h", bus_out);
            end else begin
               logic [7:0] e;
               e = q_bus.pop_front();
               if (bus_out !== e) begin
                  n_err++;
                  $display("FAIL bus_out: got %h required %h", bus_out, e);
               end
            end
         end

         if (fault && !prev_fault) begin
            n_cmp++;
            if (q_fault.size() == 0) begin
               n_err++;
               $display("FAIL fault: unexpected fault (req=%b waited=%0d)", rom_bus.rom_req, nak);
            end else begin
               logic [8:0] e;
               e = q_fault.pop_front();
               if ({rom_bus.rom_req, 8'(nak)} !== e) begin
                  n_err++;
                  $display("FAIL fault: got req=%b waited=%0d required req=%b waited=%0d",
                           rom_bus.rom_req, nak, e[8], e[7:0]);
               end
            end
         end
      end
      prev_req   = rom_bus.rom_req;
      prev_iv    = instr_valid;
      prev_fault = fault;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!rom_bus.rom_req && k < 20) begin
         tick();
         k++;
      end
      if (!rom_bus.rom_req) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_req: no rom_req within 20 cycles");
      end
   endtask

   task automatic respond(input int delay, input logic [7:0] data);
      wait_req();
      repeat (delay) tick();
      rom_bus.rom_ack  = 1'b1;
      rom_bus.rom_data = data;
      tick();
      rom_bus.rom_ack  = 1'b0;
      rom_bus.rom_data = '0;
   endtask

   task automatic exec(input logic [27:0] c, input logic [7:0] b);
      ctrl_signals = c;
      bus_in       = b;
      tick();
      ctrl_signals = '0;
      bus_in       = '0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      rom_bus.rom_ack  = 1'b0;
      rom_bus.rom_data = '0;

      // 1: reset release, ack after 2 cycles
      repeat (3) tick();
      q_req.push_back(16'h0000);
      q_fetch.push_back({8'hA5, 16'h0001});
      rst_n = 1'b1;
      respond(2, 8'hA5);

      // 2: PC load high then low, EOI -> fetch at 1234 (zero-wait ack)
      exec(C_HC, 8'h12);
      exec(C_LC, 8'h34);
      q_req.push_back(16'h1234);
      q_fetch.push_back({8'hC3, 16'h1235});
      exec(C_EOI, 8'h00);
      respond(0, 8'hC3);

      // 3: both car + EOI in one cycle -> fetch at FFFF, wrap to 0000; operand read
      q_req.push_back(16'hFFFF);
      q_fetch.push_back({8'h77, 16'h0000});
      exec(C_HC | C_LC | C_EOI, 8'hFF);
      respond(1, 8'h77);
      exec(C_CS, 8'h00);            // ROMcs alone: no action
      exec(C_RD, 8'h00);            // ROMrd alone: no action
      q_req.push_back(16'h0000);
      q_bus.push_back(8'h5C);
      exec(C_CS | C_RD, 8'h00);
      respond(1, 8'h5C);
      tick();
      q_bus.push_back(8'h01);
      exec(C_LB, 8'h00);
      q_bus.push_back(8'h00);
      exec(C_HB, 8'h00);

      // 4: pc=BEEF on the bus, then conflict -> fault, HALT ignores strobes
      exec(C_HC, 8'hBE);
      exec(C_LC, 8'hEF);
      q_bus.push_back(8'hBE);
      exec(C_HB, 8'h00);
      q_bus.push_back(8'hEF);
      exec(C_LB, 8'h00);
      q_fault.push_back({1'b0, 8'd0});
      exec(C_HB | C_LB, 8'h00);
      exec(C_EOI, 8'h00);
      exec(C_HB, 8'h00);
      exec(C_CS | C_RD, 8'h00);
      tick();

      // 5: ROM timeout after MAX_WAIT cycles, then reset recovers
      reset_pulse();
      q_req.push_back(16'h0000);
      q_fault.push_back({1'b0, 8'd15});
      rst_n = 1'b1;
      begin
         int k;
         k = 0;
         while (!fault && k < 40) begin
            tick();
            k++;
         end
         if (!fault) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: fault not raised within 40 cycles");
         end
      end
      repeat (2) tick();
      reset_pulse();
      q_req.push_back(16'h0000);
      q_fetch.push_back({8'h3E, 16'h0001});
      rst_n = 1'b1;
      respond(0, 8'h3E);

      // 6: EOI with ROMcs&ROMrd -> plain fetch at pc; then reset mid-fetch
      q_req.push_back(16'h0001);
      q_fetch.push_back({8'h99, 16'h0002});
      exec(C_EOI | C_CS | C_RD, 8'h00);
      respond(0, 8'h99);
      q_req.push_back(16'h0002);
      exec(C_EOI, 8'h00);
      wait_req();
      tick();
      reset_pulse();
      q_req.push_back(16'h0000);
      q_fetch.push_back({8'h11, 16'h0001});
      rst_n = 1'b1;
      respond(0, 8'h11);
      repeat (4) tick();

      // every expectation must have been consumed
      n_cmp++;
      if (q_req.size() != 0) begin
         n_err++;
         $display("FAIL req_left: %0d pending, required 0", q_req.size());
      end
      n_cmp++;
      if (q_fetch.size() != 0) begin
         n_err++;
         $display("FAIL fetch_left: %0d pending, required 0", q_fetch.size());
      end
      n_cmp++;
      if (q_bus.size() != 0) begin
         n_err++;
         $display("FAIL bus_left: %0d pending, required 0", q_bus.size());
      end
      n_cmp++;
      if (q_fault.size() != 0) begin
         n_err++;
         $display("FAIL fault_left: %0d pending, required 0", q_fault.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
